// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared types and constants.
// No logic; referenced by the frame receiver and the scan-code map.
// No flow control; constants only.
package ps2_pkg;

  // Frame receiver states, one per section of the 11-bit PS/2 frame
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Set-2 prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Game keycodes consumed by the player-motion logic
  localparam logic [15:0] KEY_UP    = 16'h001A;
  localparam logic [15:0] KEY_LEFT  = 16'h0004;
  localparam logic [15:0] KEY_DOWN  = 16'h0016;
  localparam logic [15:0] KEY_RIGHT = 16'h0007;
  localparam logic [15:0] KEY_NONE  = 16'h0000;

endpackage

// File: rtl/ps2_scan_map.sv
// Translates a set-2 scan code (with extended flag) into a game keycode.
// Purely combinational, zero latency.
// No flow control; valid is low for codes that have no game meaning.
module ps2_scan_map
  import ps2_pkg::*;
(
  input  logic        ext,
  input  logic [7:0]  code,
  output logic        valid,
  output logic [15:0] game_key
);

  // WASD on the main block and the four arrows on the extended block share keycodes
  always_comb begin
    valid    = 1'b1;
    game_key = KEY_NONE;
    case ({ext, code})
      {1'b0, 8'h1D}, {1'b1, 8'h75}: game_key = KEY_UP;
      {1'b0, 8'h1C}, {1'b1, 8'h6B}: game_key = KEY_LEFT;
      {1'b0, 8'h1B}, {1'b1, 8'h72}: game_key = KEY_DOWN;
      {1'b0, 8'h23}, {1'b1, 8'h74}: game_key = KEY_RIGHT;
      default: begin
        valid    = 1'b0;
        game_key = KEY_NONE;
      end
    endcase
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver: sync, frame check, E0/F0 prefix tracking, held-key output.
// Outputs update on the clock edge ending the cycle in which the stop-bit fall is seen.
// No backpressure: the keyboard cannot be stalled; keycode is a level, strobes are one cycle.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [15:0] keycode,
  output logic        key_press,
  output logic        frame_err
);

  // Synchroniser flops; reset to 1 so the idle-high line never looks like an edge
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;
  logic din;

  // Frame and output state
  ps2_state_t  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [15:0] keycode_q, keycode_d;
  logic        key_press_q, key_press_d;
  logic        frame_err_q, frame_err_d;

  logic        frame_ok;
  logic        timeout;
  logic        map_valid;
  logic [15:0] map_key;

  // Two-flop synchronisers, plus a third clock flop for falling-edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= PS2_DATA;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;
  assign din  = dat_s2_q;

  // In the STOP state din is the stop bit; odd parity over data plus parity bit
  assign frame_ok = din & (^shift_q ^ parity_q);

  // A stalled frame is abandoned; a fall in the same cycle takes precedence
  assign timeout = (state_q != IDLE) && !fall &&
                   (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  ps2_scan_map u_scan_map (
    .ext      (ext_q),
    .code     (shift_q),
    .valid    (map_valid),
    .game_key (map_key)
  );

  // Next-state logic: frame FSM, idle counter, prefix flags and key output
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    idle_cnt_d  = idle_cnt_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    keycode_d   = keycode_q;
    key_press_d = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == IDLE || fall) begin
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        // A high bit on a fall is line noise between frames and is ignored
        if (fall && !din) begin
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {din, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = din;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!frame_ok) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end else if (shift_q == PS2_EXT) begin
            ext_d = 1'b1;
          end else if (shift_q == PS2_BRK) begin
            brk_d = 1'b1;
          end else begin
            if (map_valid) begin
              if (!brk_q) begin
                // Typematic repeats strobe again even with an unchanged keycode
                keycode_d   = map_key;
                key_press_d = 1'b1;
              end else if (map_key == keycode_q) begin
                keycode_d = KEY_NONE;
              end
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d     = IDLE;
      idle_cnt_d  = '0;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end
  end

  // State registers; reset discards any partial frame and pending prefixes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      idle_cnt_q  <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      keycode_q   <= KEY_NONE;
      key_press_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      idle_cnt_q  <= idle_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      keycode_q   <= keycode_d;
      key_press_q <= key_press_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_press = key_press_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: directed PS/2 frames with a scoreboard of expected output events.
// An event is any cycle with key_press, frame_err, or a keycode change.
// Keyboard side has no flow control; frames are spaced by a fixed idle gap.
module tb_ps2_keycode;

  localparam int HALF = 6;  // Clk cycles per PS/2 clock half-period

  logic        Clk;
  logic        Reset;
  logic        PS2_CLK;
  logic        PS2_DATA;
  logic [15:0] keycode;
  logic        key_press;
  logic        frame_err;

  int vectors     = 0;
  int miscompares = 0;
  logic mon_en    = 1'b0;

  // Expected events: {key_press, frame_err, keycode}
  logic [17:0] exp_q[$];

  ps2_keycode dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .keycode   (keycode),
    .key_press (key_press),
    .frame_err (frame_err)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got kp/fe/key=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge Clk);
    PS2_DATA = b;
    repeat (HALF) @(negedge Clk);
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge Clk);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stp);
    PS2_DATA = 1'b1;
    repeat (20) @(negedge Clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    PS2_DATA = 1'b1;
  endtask

  task automatic expect_ev(input logic kp, input logic fe, input logic [15:0] kc);
    exp_q.push_back({kp, fe, kc});
  endtask

  // Monitor: compare every observed output event against the scoreboard head
  initial begin
    logic [15:0] prev_kc;
    logic [17:0] e;
    prev_kc = 16'h0000;
    forever begin
      @(negedge Clk);
      if (mon_en && (key_press || frame_err || keycode != prev_kc)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got kp=%b fe=%b key=%h, expected no event",
                   key_press, frame_err, keycode);
        end else begin
          e = exp_q.pop_front();
          check("event", {key_press, frame_err, keycode}, e);
        end
      end
      prev_kc = keycode;
    end
  end

  // Stimulus with hand-computed odd-parity bits
  initial begin
    Reset    = 1'b1;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset_keycode",   {2'b00, keycode},   18'h0);
    check("reset_key_press", {17'h0, key_press}, 18'h0);
    check("reset_frame_err", {17'h0, frame_err}, 18'h0);
    Reset  = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge Clk);

    // W make
    expect_ev(1'b1, 1'b0, 16'h001A); send_frame(8'h1D, 1'b1, 1'b1);
    // W break: no strobe on F0, keycode clears on 1D
    send_frame(8'hF0, 1'b1, 1'b1);
    expect_ev(1'b0, 1'b0, 16'h0000); send_frame(8'h1D, 1'b1, 1'b1);
    // Up arrow make then break
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h001A); send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    expect_ev(1'b0, 1'b0, 16'h0000); send_frame(8'h75, 1'b0, 1'b1);
    // A make, then release of a key not held
    expect_ev(1'b1, 1'b0, 16'h0004); send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1D, 1'b1, 1'b1);
    check("held_after_other_break", {2'b00, keycode}, {2'b00, 16'h0004});
    // Bad parity, then S proves prefixes are clean
    expect_ev(1'b0, 1'b1, 16'h0004); send_frame(8'h1D, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h0016); send_frame(8'h1B, 1'b1, 1'b1);
    // Typematic repeat through Down arrow: same value, new strobe
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h0016); send_frame(8'h72, 1'b1, 1'b1);
    // Left and Right arrows
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h0004); send_frame(8'h6B, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h0007); send_frame(8'h74, 1'b1, 1'b1);
    // Unmapped code: nothing
    send_frame(8'h15, 1'b0, 1'b1);
    // Bad stop bit
    expect_ev(1'b0, 1'b1, 16'h0007); send_frame(8'h23, 1'b0, 1'b0);
    // Error after E0 clears ext: plain 75 is unmapped, E0 75 maps to Up
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(1'b0, 1'b1, 16'h0007); send_frame(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h001A); send_frame(8'h75, 1'b0, 1'b1);
    // Error after F0 clears brk: 1D is then a make, not a release
    send_frame(8'hF0, 1'b1, 1'b1);
    expect_ev(1'b0, 1'b1, 16'h001A); send_frame(8'h1C, 1'b1, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h001A); send_frame(8'h1D, 1'b1, 1'b1);
    // Timeout after 4 data bits, then D
    expect_ev(1'b0, 1'b1, 16'h001A);
    send_partial(8'h23, 4);
    repeat (50100) @(negedge Clk);
    expect_ev(1'b1, 1'b0, 16'h0007); send_frame(8'h23, 1'b0, 1'b1);
    // Reset mid-frame with a pending E0 prefix
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(1'b0, 1'b0, 16'h0000);
    send_partial(8'h75, 3);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midreset_keycode",   {2'b00, keycode},   18'h0);
    check("midreset_key_press", {17'h0, key_press}, 18'h0);
    check("midreset_frame_err", {17'h0, frame_err}, 18'h0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    // Prefix was lost: 75 alone is unmapped; then A works normally
    send_frame(8'h75, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 16'h0004); send_frame(8'h1C, 1'b0, 1'b1);

    repeat (50) @(negedge Clk);
    check("events_outstanding", 18'(exp_q.size()), 18'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
